// File: rtl/traffic_event_sequencer_if.sv
// Event handshake and simulator-facing bus of the traffic event sequencer.
// master drives events and display requests; slave is the sequencer itself.
interface traffic_event_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             evt_valid;
  logic [1:0]       evt_type;
  logic [4:0]       evt_plate;
  logic             display_req;
  logic             evt_ready;
  logic [2:0]       mode;
  logic [4:0]       plateIn;
  logic             action;
  logic [4:0]       cars_a;
  logic [4:0]       cars_b;
  logic             reject;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output evt_valid, evt_type, evt_plate, display_req,
    input  evt_ready, mode, plateIn, action, cars_a, cars_b, reject, fifo_count
  );

  modport slave (
    input  evt_valid, evt_type, evt_plate, display_req,
    output evt_ready, mode, plateIn, action, cars_a, cars_b, reject, fifo_count
  );
endinterface

// File: rtl/traffic_event_sequencer.sv
// Queues lane add/remove events and replays them to an intersection simulator
// as SETUP/PULSE/HOLD sequences, tracking shadow lane occupancy.
module traffic_event_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LANE_MAX = 31
) (
  input  logic                     clk,
  input  logic                     rst_n,
  traffic_event_sequencer_if.slave bus
);
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [4:0]  LANE_TOP = 5'(LANE_MAX);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [6:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rdy_en;
  logic [2:0]       r_mode;
  logic [4:0]       r_plate;
  logic [1:0]       r_op;
  logic             r_action;
  logic             r_reject;
  logic [4:0]       r_cars_a;
  logic [4:0]       r_cars_b;

  logic             w_push;
  logic             w_pop;
  logic             w_bad;
  logic [1:0]       w_head_type;
  logic [4:0]       w_head_plate;
  logic [4:0]       w_lane_cnt;
  logic [2:0]       w_mode_nxt;
  logic [4:0]       w_plate_nxt;
  logic [1:0]       w_op_nxt;
  logic             w_reject_nxt;

  // r_rdy_en holds ready low through reset and releases it one edge later
  assign bus.evt_ready = r_rdy_en && (r_count < CNT_W'(DEPTH));

  assign w_push = bus.evt_valid && bus.evt_ready;
  assign w_pop  = (r_state == IDLE) && (r_count != '0);

  assign {w_head_type, w_head_plate} = r_mem[r_rd_ptr];
  assign w_lane_cnt = w_head_type[0] ? r_cars_b : r_cars_a;
  assign w_bad      = w_head_type[1] ? (w_lane_cnt >= LANE_TOP) : (w_lane_cnt == 5'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pop && !w_bad) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = PULSE;
      PULSE:   w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: mode/plate only move in IDLE, so they hold across SETUP..HOLD
  always_comb begin
    w_mode_nxt   = r_mode;
    w_plate_nxt  = r_plate;
    w_op_nxt     = r_op;
    w_reject_nxt = 1'b0;
    if (r_state == IDLE) begin
      if (w_pop) begin
        w_reject_nxt = w_bad;
        if (!w_bad) begin
          w_op_nxt   = w_head_type;
          w_mode_nxt = {1'b0, w_head_type};
          if (w_head_type[1]) w_plate_nxt = w_head_plate;
        end
      end else if (bus.display_req) begin
        w_mode_nxt = 3'b100;
      end else begin
        w_mode_nxt = {1'b0, r_op};
      end
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.evt_type, bus.evt_plate};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= 3'b000;
      r_plate  <= 5'd0;
      r_op     <= 2'b00;
      r_action <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_plate  <= w_plate_nxt;
      r_op     <= w_op_nxt;
      r_action <= (w_state_nxt == PULSE);
      r_reject <= w_reject_nxt;
    end
  end

  // Lane counts commit on the edge leaving PULSE, saturating at both ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cars_a <= 5'd0;
      r_cars_b <= 5'd0;
    end else if (r_state == PULSE) begin
      case (r_op)
        2'b00:   if (r_cars_a != 5'd0)     r_cars_a <= r_cars_a - 5'd1;
        2'b01:   if (r_cars_b != 5'd0)     r_cars_b <= r_cars_b - 5'd1;
        2'b10:   if (r_cars_a < LANE_TOP)  r_cars_a <= r_cars_a + 5'd1;
        default: if (r_cars_b < LANE_TOP)  r_cars_b <= r_cars_b + 5'd1;
      endcase
    end
  end

  assign bus.mode       = r_mode;
  assign bus.plateIn    = r_plate;
  assign bus.action     = r_action;
  assign bus.reject     = r_reject;
  assign bus.cars_a     = r_cars_a;
  assign bus.cars_b     = r_cars_b;
  assign bus.fifo_count = r_count;

endmodule

// File: tb/tb_traffic_event_sequencer.sv
// Directed bench for traffic_event_sequencer: latency, rejects, FIFO backpressure,
// display priority, lane saturation and reset during PULSE.
module tb_traffic_event_sequencer;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned LANE_MAX = 31;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  traffic_event_sequencer_if #(.DEPTH(DEPTH)) bus ();

  traffic_event_sequencer #(.DEPTH(DEPTH), .LANE_MAX(LANE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Negedge monitor: logs every action pulse (cycle and plate) and reject pulse
  int         cyc   = 0;
  int         n_act = 0;
  int         n_rej = 0;
  int         n_dbl = 0;
  int         act_cyc   [128];
  logic [4:0] act_plate [128];
  logic       prev_act = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.action && prev_act) n_dbl++;
    if (bus.action) begin
      if (n_act < 128) begin
        act_cyc[n_act]   = cyc;
        act_plate[n_act] = bus.plateIn;
      end
      n_act++;
    end
    if (bus.reject) n_rej++;
    prev_act = bus.action;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input logic [1:0] typ, input logic [4:0] plate);
    check("push_ready", 32'(bus.evt_ready), 32'd1);
    bus.evt_valid = 1'b1;
    bus.evt_type  = typ;
    bus.evt_plate = plate;
    tick(1);
    bus.evt_valid = 1'b0;
  endtask

  task automatic push_stream(input int n, input logic [1:0] typ, input int plate_base,
                             output int max_cnt, output logic full_blocked);
    int   k     = 0;
    int   guard = 0;
    logic rdy;
    max_cnt      = 0;
    full_blocked = 1'b0;
    while (k < n && guard < 400) begin
      bus.evt_valid = 1'b1;
      bus.evt_type  = typ;
      bus.evt_plate = 5'(plate_base + k);
      rdy = bus.evt_ready;
      tick(1);
      guard++;
      if (rdy) k++;
      if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
      if (int'(bus.fifo_count) == DEPTH && !bus.evt_ready) full_blocked = 1'b1;
    end
    bus.evt_valid = 1'b0;
    check("push_stream_done", 32'(k), 32'(n));
  endtask

  task automatic drain();
    int guard = 0;
    while (bus.fifo_count != '0 && guard < 500) begin
      tick(1);
      guard++;
    end
    check("drain_in_time", 32'(guard < 500), 32'd1);
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int   a0;
    int   r0;
    int   mx;
    logic fb;

    bus.evt_valid   = 1'b0;
    bus.evt_type    = 2'b00;
    bus.evt_plate   = 5'd0;
    bus.display_req = 1'b0;

    // Reset values
    #12;
    check("rst_ready",  32'(bus.evt_ready),  32'd0);
    check("rst_mode",   32'(bus.mode),       32'd0);
    check("rst_plate",  32'(bus.plateIn),    32'd0);
    check("rst_action", 32'(bus.action),     32'd0);
    check("rst_reject", 32'(bus.reject),     32'd0);
    check("rst_cars_a", 32'(bus.cars_a),     32'd0);
    check("rst_cars_b", 32'(bus.cars_b),     32'd0);
    check("rst_count",  32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.evt_ready), 32'd0);
    tick(1);
    check("ready_after_edge", 32'(bus.evt_ready), 32'd1);

    // addA plate 9: latency of load, pulse and count update
    push_one(2'b10, 5'd9);
    check("a_t0_count",  32'(bus.fifo_count), 32'd1);
    check("a_t0_mode",   32'(bus.mode),       32'd0);
    check("a_t0_action", 32'(bus.action),     32'd0);
    tick(1);
    check("a_t1_mode",   32'(bus.mode),       32'd2);
    check("a_t1_plate",  32'(bus.plateIn),    32'd9);
    check("a_t1_action", 32'(bus.action),     32'd0);
    check("a_t1_count",  32'(bus.fifo_count), 32'd0);
    tick(1);
    check("a_t2_action", 32'(bus.action),     32'd1);
    check("a_t2_cars_a", 32'(bus.cars_a),     32'd0);
    tick(1);
    check("a_t3_action", 32'(bus.action),     32'd0);
    check("a_t3_cars_a", 32'(bus.cars_a),     32'd1);
    check("a_t3_mode",   32'(bus.mode),       32'd2);
    tick(1);

    // remB on an empty lane is rejected
    a0 = n_act;
    r0 = n_rej;
    push_one(2'b01, 5'd0);
    tick(1);
    check("rb_reject",  32'(bus.reject),  32'd1);
    check("rb_mode",    32'(bus.mode),    32'd2);
    check("rb_plate",   32'(bus.plateIn), 32'd9);
    tick(1);
    check("rb_reject_end", 32'(bus.reject), 32'd0);
    tick(4);
    check("rb_no_action", 32'(n_act - a0), 32'd0);
    check("rb_one_rej",   32'(n_rej - r0), 32'd1);
    check("rb_cars_b",    32'(bus.cars_b), 32'd0);

    // Five back-to-back addB pushes through a 4-deep FIFO
    a0 = n_act;
    push_stream(5, 2'b11, 1, mx, fb);
    check("bb_max_count",    32'(mx), 32'(DEPTH));
    check("bb_full_blocked", 32'(fb), 32'd1);
    drain();
    check("bb_pulses", 32'(n_act - a0), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("bb_plate%0d", i), 32'(act_plate[a0 + i]), 32'(i + 1));
    for (int i = 0; i < 4; i++)
      check($sformatf("bb_gap%0d", i), 32'(act_cyc[a0 + i + 1] - act_cyc[a0 + i]), 32'd4);
    check("bb_cars_b", 32'(bus.cars_b), 32'd5);

    // Display mode and its lower priority than a pending event
    bus.display_req = 1'b1;
    tick(1);
    check("d_mode_disp", 32'(bus.mode), 32'd4);
    push_one(2'b11, 5'd7);
    check("d_mode_pend", 32'(bus.mode), 32'd4);
    tick(1);
    check("d_mode_op",  32'(bus.mode),    32'd3);
    check("d_plate",    32'(bus.plateIn), 32'd7);
    tick(3);
    check("d_mode_hold", 32'(bus.mode), 32'd3);
    tick(1);
    check("d_mode_back", 32'(bus.mode),   32'd4);
    check("d_cars_b",    32'(bus.cars_b), 32'd6);
    bus.display_req = 1'b0;
    tick(1);
    check("d_mode_last_op", 32'(bus.mode), 32'd3);

    // Reset asserted during PULSE with events still queued
    push_one(2'b10, 5'd2);
    push_one(2'b11, 5'd3);
    push_one(2'b11, 5'd4);
    check("r_in_pulse", 32'(bus.action),     32'd1);
    check("r_queued",   32'(bus.fifo_count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_action", 32'(bus.action),     32'd0);
    check("r_count",  32'(bus.fifo_count), 32'd0);
    check("r_cars_a", 32'(bus.cars_a),     32'd0);
    check("r_cars_b", 32'(bus.cars_b),     32'd0);
    check("r_ready",  32'(bus.evt_ready),  32'd0);
    check("r_mode",   32'(bus.mode),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("r_ready_back", 32'(bus.evt_ready), 32'd1);
    tick(3);
    check("r_lost_update", 32'(bus.cars_a), 32'd0);

    // 32 addA events saturate lane A at LANE_MAX
    a0 = n_act;
    r0 = n_rej;
    push_stream(32, 2'b10, 0, mx, fb);
    drain();
    check("sat_pulses",  32'(n_act - a0),   32'd31);
    check("sat_rejects", 32'(n_rej - r0),   32'd1);
    check("sat_cars_a",  32'(bus.cars_a),   32'(LANE_MAX));
    check("sat_last_plate", 32'(act_plate[a0 + 30]), 32'd30);

    push_one(2'b00, 5'd0);
    tick(5);
    check("rem_a_cars_a", 32'(bus.cars_a), 32'd30);
    check("rem_a_mode",   32'(bus.mode),   32'd0);
    check("no_double_action", 32'(n_dbl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/traffic_event_sequencer.md
TRAFFIC_EVENT_SEQUENCER -- requirements
Module: traffic_event_sequencer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, the event FIFO depth (power of two, 2..16).
REQ-002 The module SHALL have parameter LANE_MAX, default 31, the maximum car count tracked per lane.
REQ-003 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 evt_valid  input  1  upstream event request.
REQ-007 evt_type  input  2  event code: 00 remA, 01 remB, 10 addA, 11 addB.
REQ-008 evt_plate  input  5  plate number for add events; ignored for removals.
REQ-009 display_req  input  1  request for display mode on the downstream simulator.
REQ-010 evt_ready  output  1  FIFO can accept an event.
REQ-011 mode  output  3  mode bus to the intersection simulator.
REQ-012 plateIn  output  5  plate bus to the intersection simulator.
REQ-013 action  output  1  single-cycle strobe to the intersection simulator.
REQ-014 cars_a, cars_b  output  5 each  shadow lane occupancy counts.
REQ-015 reject  output  1  one-cycle pulse when a popped event is discarded.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 evt_ready SHALL equal (fifo_count < DEPTH) and depend only on the registered count.
REQ-018 An event SHALL be written to the FIFO tail on any edge where evt_valid && evt_ready; a push while full SHALL be blocked even if a pop occurs on the same edge.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-020 The FSM SHALL have exactly four states, IDLE, SETUP, PULSE and HOLD, and SHALL reset to IDLE.
REQ-021 In IDLE, when the FIFO is non-empty, the head SHALL be popped and checked on that edge.
REQ-022 A popped removal for a lane whose shadow count is 0 SHALL be discarded: reject=1 for one cycle, state stays IDLE, and mode, plateIn and counts are unchanged.
REQ-023 A popped add for a lane whose shadow count equals LANE_MAX SHALL be discarded in the same way.
REQ-024 A valid popped event SHALL load mode={1'b0,evt_type}; for adds, plateIn SHALL load evt_plate, and for removals plateIn SHALL hold its value. State SHALL then go to SETUP.
REQ-025 SETUP SHALL last one cycle with action=0 and SHALL go to PULSE.
REQ-026 PULSE SHALL last one cycle with action=1 and SHALL go to HOLD; the shadow count of the addressed lane SHALL be updated (+1 add, -1 remove) on the edge leaving PULSE.
REQ-027 HOLD SHALL last one cycle with action=0 and SHALL go to IDLE.
REQ-028 mode and plateIn SHALL be stable from entry to SETUP through exit from HOLD.
REQ-029 Latency: for an event accepted at edge t into an empty FIFO in IDLE, action SHALL be 1 exactly during the cycle after edge t+2; back-to-back events SHALL produce action pulses 4 cycles apart.
REQ-030 action SHALL never be high for two consecutive cycles.
REQ-031 In IDLE with the FIFO empty and display_req=1, mode SHALL be 3'b100; display SHALL have lower priority than pending events.
REQ-032 When display_req falls, or an event is popped, mode SHALL return to the last operation code.
REQ-033 Shadow counts SHALL never wrap below 0 or above LANE_MAX.

Reset
REQ-034 While rst_n=0: state IDLE, FIFO empty, fifo_count=0, evt_ready=0, mode=3'b000, plateIn=0, action=0, reject=0, cars_a=0, cars_b=0.
REQ-035 Reset asserted mid-sequence (including during PULSE) SHALL immediately force action=0 and discard all queued events; the count update of the interrupted event SHALL be lost.
REQ-036 evt_ready SHALL assert on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Add A, plate 5'd9, into an empty idle block: mode=010 and plateIn=9 from edge t+1; action=1 only after edge t+2; cars_a=1 after edge t+3.
REQ-038 remB with cars_b=0: reject pulses once; no action pulse; mode unchanged; cars_b stays 0.
REQ-039 Push 5 events back-to-back with DEPTH=4: evt_ready drops while fifo_count=4; all accepted events issue in order, with action pulses 4 cycles apart.
REQ-040 display_req=1 with the FIFO empty: mode=100. Then push addB: mode=011, the sequence completes, and mode returns to 100 in IDLE.
REQ-041 Push 32 addA events: the first 31 issue and the 32nd rejects; cars_a=31.
REQ-042 Assert rst_n=0 during PULSE: action=0 immediately, fifo_count=0, and cars_a/cars_b=0.
